// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared constants and types for the SRAM arbiter
// Contents: access size codes, response tag encoding, default starvation limit.
// Ports: none (package).
package sram_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Response tag: which requester owns the read data returning next cycle.
  typedef enum logic {
    ARB_SEL_INST = 1'b0,
    ARB_SEL_DATA = 1'b1
  } arb_sel_e;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch, load/store and SRAM signal bundle for sram_arbiter
// Ports (signals):
//   inst_req/inst_addr -> inst_addr_ok/inst_data_ok/inst_rdata   fetch port
//   data_req/data_wr/data_size/data_addr/data_wdata
//     -> data_addr_ok/data_data_ok/data_rdata                     load/store port
//   ram_en/ram_we/ram_addr/ram_wdata <- arbiter, ram_rdata -> arbiter
// Modports: master = requesters plus SRAM model side, slave = arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // ram_rdata comes from the memory, which lives on the master side.
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output ram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  ram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/sram_wstrb_gen.sv
// rtl/sram_wstrb_gen.sv - byte write-enable generator from access size and address
// Ports:
//   wr      in  1  store (1) or load (0)
//   size    in  2  0 byte, 1 half, 2 word, 3 reserved (no write)
//   addr_lo in  2  byte offset within the word
//   we      out 4  per-byte write enables
module sram_wstrb_gen
  import sram_arbiter_pkg::*;
(
  input  logic       wr,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] we
);

  always_comb begin
    we = 4'b0000;
    if (wr) begin
      case (size)
        SIZE_BYTE: we = 4'b0001 << addr_lo;
        SIZE_HALF: we = 4'b0011 << {addr_lo[1], 1'b0};
        SIZE_WORD: we = 4'b1111;
        default:   we = 4'b0000;  // reserved size completes as a no-op
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM between fetch and load/store ports
// Ports:
//   clk     in  1  system clock
//   resetn  in  1  asynchronous active-low reset
//   bus     sram_arbiter_if.slave  requester handshakes and SRAM drive
// Parameters: ADDR_W, DATA_W (32), STARVE_MAX (1..15, fixed-priority mode only).
// Option: SRAM_ARB_RR_EN selects round-robin arbitration instead of data
//   priority with a starvation counter.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  sram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  logic       ready;
  logic       gnt_i;
  logic       gnt_d;
  logic       resp_vld;
  arb_sel_e   resp_sel;
  logic [3:0] store_we;

  // Holds every output quiet for one cycle after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready <= 1'b0;
    else         ready <= 1'b1;
  end

`ifdef SRAM_ARB_RR_EN
  arb_sel_e rr_last;

  // On contention the port that did not win last time is served.
  assign gnt_d = ready && bus.data_req && (!bus.inst_req || rr_last == ARB_SEL_INST);
  assign gnt_i = ready && bus.inst_req && !gnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rr_last <= ARB_SEL_DATA;
    else if (gnt_d) rr_last <= ARB_SEL_DATA;
    else if (gnt_i) rr_last <= ARB_SEL_INST;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  // Data wins contention until inst has lost STARVE_MAX cycles in a row.
  assign gnt_d = ready && bus.data_req && (!bus.inst_req || starve_cnt < STARVE_LIM);
  assign gnt_i = ready && bus.inst_req && !gnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 starve_cnt <= 4'd0;
    else if (!bus.inst_req || gnt_i)             starve_cnt <= 4'd0;
    else if (gnt_d && starve_cnt < STARVE_LIM)   starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  sram_wstrb_gen u_wstrb (
    .wr      (bus.data_wr),
    .size    (bus.data_size),
    .addr_lo (bus.data_addr[1:0]),
    .we      (store_we)
  );

  assign bus.inst_addr_ok = gnt_i;
  assign bus.data_addr_ok = gnt_d;

  assign bus.ram_en    = gnt_i | gnt_d;
  assign bus.ram_we    = gnt_d ? store_we : 4'b0000;
  assign bus.ram_addr  = gnt_d ? (bus.data_addr & WORD_MASK)
                       : gnt_i ? (bus.inst_addr & WORD_MASK)
                       : '0;
  assign bus.ram_wdata = gnt_d ? bus.data_wdata : '0;

  // Tag each access so the next-cycle read data reaches its owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_vld <= 1'b0;
      resp_sel <= ARB_SEL_INST;
    end else begin
      resp_vld <= gnt_i | gnt_d;
      resp_sel <= gnt_d ? ARB_SEL_DATA : ARB_SEL_INST;
    end
  end

  assign bus.inst_data_ok = resp_vld && (resp_sel == ARB_SEL_INST);
  assign bus.data_data_ok = resp_vld && (resp_sel == ARB_SEL_DATA);
  assign bus.inst_rdata   = ready ? bus.ram_rdata : '0;
  assign bus.data_rdata   = ready ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    bit          gi;
    bit          gd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    bit          sel_d;
    logic [31:0] rdata;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int          n_vec  = 0;
  int          n_bad  = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  int          lose   = 0;     // consecutive cycles inst has lost to data
  bit          last_d = 1'b1;  // last grant went to data
  logic [31:0] rdata_plan = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ram_en"},       bus.ram_en,       0);
    chk({tag, ".ram_we"},       bus.ram_we,       0);
    chk({tag, ".ram_addr"},     bus.ram_addr,     0);
    chk({tag, ".ram_wdata"},    bus.ram_wdata,    0);
    chk({tag, ".inst_addr_ok"}, bus.inst_addr_ok, 0);
    chk({tag, ".data_addr_ok"}, bus.data_addr_ok, 0);
    chk({tag, ".inst_data_ok"}, bus.inst_data_ok, 0);
    chk({tag, ".data_data_ok"}, bus.data_data_ok, 0);
    chk({tag, ".inst_rdata"},   bus.inst_rdata,   0);
    chk({tag, ".data_rdata"},   bus.data_rdata,   0);
  endtask

  // Byte enables from size and offset with plain arithmetic.
  function automatic logic [3:0] exp_we(input bit wr, input int size, input int off);
    int v;
    if (!wr) return 4'h0;
    case (size)
      0:       v = 1 << off;
      1:       v = 3 << ((off / 2) * 2);
      2:       v = 15;
      default: v = 0;
    endcase
    return 4'(v);
  endfunction

  // Drive one cycle of requests and record what the arbiter must do.
  task automatic apply(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dwd);
    gexp_t g;
    rexp_t r;
    bit gi, gd;
    @(posedge clk);
    #1;
    bus.inst_req   = ir;
    bus.inst_addr  = ia;
    bus.data_req   = dr;
    bus.data_wr    = dw;
    bus.data_size  = ds;
    bus.data_addr  = da;
    bus.data_wdata = dwd;
    bus.ram_rdata  = rdata_plan;
`ifdef SRAM_ARB_RR_EN
    gd = (ir && dr) ? !last_d : dr;
    gi = ir && !gd;
    if (gi)      last_d = 1'b0;
    else if (gd) last_d = 1'b1;
`else
    gd = (ir && dr) ? (lose < SMAX) : dr;
    gi = ir && !gd;
    lose = (ir && gd) ? lose + 1 : 0;
`endif
    g.cyc   = cyc;
    g.gi    = gi;
    g.gd    = gd;
    g.we    = gd ? exp_we(dw, int'(ds), int'(da[1:0])) : 4'h0;
    g.addr  = gd ? {da[31:2], 2'b00} : {ia[31:2], 2'b00};
    g.wdata = dwd;
    gq.push_back(g);
    if (gi || gd) begin
      rdata_plan = $urandom;
      r.cyc   = cyc + 1;
      r.sel_d = gd;
      r.rdata = rdata_plan;
      rq.push_back(r);
    end
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (mon_en) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        chk("inst_addr_ok", bus.inst_addr_ok, g.gi);
        chk("data_addr_ok", bus.data_addr_ok, g.gd);
        chk("ram_en", bus.ram_en, g.gi | g.gd);
        chk("ram_we", bus.ram_we, g.we);
        if (g.gi || g.gd) chk("ram_addr", bus.ram_addr, g.addr);
        if (g.gd) chk("ram_wdata", bus.ram_wdata, g.wdata);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("inst_data_ok", bus.inst_data_ok, !r.sel_d);
        chk("data_data_ok", bus.data_data_ok, r.sel_d);
        if (r.sel_d) chk("data_rdata", bus.data_rdata, r.rdata);
        else         chk("inst_rdata", bus.inst_rdata, r.rdata);
      end else begin
        chk("inst_data_ok_idle", bus.inst_data_ok, 0);
        chk("data_data_ok_idle", bus.data_data_ok, 0);
      end
    end
  end

  initial begin
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h1c000004;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd2;
    bus.data_addr  = 32'h00002000;
    bus.data_wdata = 32'h55555555;
    bus.ram_rdata  = 32'hdeadbeef;
    resetn = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_all_zero("first_cycle");
    lose = 0; last_d = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 3; i++) apply(1'b1, 32'h1c000000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    apply(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h00001002, 32'hAAAAAAAA);
    apply(1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h00001002, 32'hAAAAAAAA);
    apply(1'b0, 32'h0, 1'b1, 1'b1, 2'd3, 32'h00001004, 32'h12345678);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h00001008, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) apply(1'b1, 32'h1c000010, 1'b1, 1'b0, 2'd2, 32'h00003000, 32'h0);
    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom, $urandom);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Reset in the middle of an access: the pending response must vanish.
    apply(1'b1, 32'h1c000020, 1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0);
    apply(1'b1, 32'h1c000020, 1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0);
    apply(1'b1, 32'h1c000020, 1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    mon_en = 1'b0;
    gq.delete();
    rq.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midreset.inst_data_ok", bus.inst_data_ok, 0);
      chk("midreset.data_data_ok", bus.data_data_ok, 0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_all_zero("after_midreset");
    lose = 0; last_d = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 2 * SMAX + 3; i++)
      apply(1'b1, 32'h1c000030, 1'b1, 1'b0, 2'd2, 32'h00005000, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("responses_outstanding", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares one single-port synchronous SRAM between the CPU fetch port (inst) and the load/store port (data).
Both ports use a req / addr_ok / data_ok handshake. The block grants one request per cycle and drives the shared SRAM. It tags each granted request so the next-cycle read data returns to the correct requester.
It sits between mycpu_top's stage logic and the external memory. It is the first step toward a unified-memory SoC.

Parameters:
ADDR_W, 32, address width for both ports and the SRAM.
DATA_W, 32, data width; must be 32.
STARVE_MAX, 4, consecutive cycles inst may lose to data before it is forced a grant (fixed-priority mode); legal range 1..15.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request valid
inst_addr  in  ADDR_W  fetch byte address, word aligned
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch read data valid this cycle
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  load/store request valid
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  load/store byte address
data_wdata  in  DATA_W  store data, already lane-replicated by the requester
data_addr_ok  out  1  load/store request accepted
data_data_ok  out  1  load data valid, or store completion
data_rdata  out  DATA_W  load data, raw word
ram_en  out  1  SRAM enable
ram_we  out  4  SRAM byte write enables
ram_addr  out  ADDR_W  SRAM address, low 2 bits forced to 0
ram_wdata  out  DATA_W  SRAM write data
ram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after ram_en

Behaviour:
- Reset (asynchronous, resetn=0): all registers clear. Clock-side effect: no grant, no data_ok, starve_cnt=0, rr_last=data. Combinational outputs are gated by a reset-synchronised ready flag, so all outputs are 0 while resetn=0 and during the first cycle after release.
- Grant is combinational, one per cycle:
  - gnt_d = data_req && (!inst_req || starve_cnt < STARVE_MAX).
  - gnt_i = inst_req && !gnt_d.
- Handshake outputs: inst_addr_ok = gnt_i; data_addr_ok = gnt_d.
- SRAM drive: ram_en = gnt_i | gnt_d; ram_addr, ram_wdata are muxed from the granted port.
- ram_we = 0 unless gnt_d && data_wr. When a store is granted:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1],1'b0}.
  - size 2: 4'b1111.
  - size 3: ram_we = 0 and the request completes as a no-op.
- Tag register: resp_vld <= ram_en and resp_sel <= gnt_d on every clock.
- Response, exactly 1 cycle after grant:
  - inst_data_ok = resp_vld && !resp_sel.
  - data_data_ok = resp_vld && resp_sel; this also fires for stores.
  - inst_rdata = data_rdata = ram_rdata.
- Throughput: one grant per cycle. Back-to-back grants to alternating ports are legal. Requesters must accept data_ok in the cycle it is asserted; there is no backpressure.
- starve_cnt (4-bit):
  - Increments when inst_req && gnt_d.
  - Clears on gnt_i or when inst_req=0.
  - Saturates at STARVE_MAX.
- Simultaneous req, normal case: data wins.
- Simultaneous req when starve_cnt == STARVE_MAX: inst wins, and the counter clears next cycle.
- Requester dropping req while its addr_ok=0: no effect; no state is kept per pending request.
- Reset asserted mid-response: the pending data_ok is dropped, with no SRAM side effect beyond the already-issued access.

Optional Feature:
SRAM_ARB_RR_EN
- When defined: round-robin arbitration replaces fixed priority plus starvation.
  - On simultaneous req, the port not equal to rr_last wins.
  - rr_last updates to the granted port on every grant.
  - starve_cnt and STARVE_MAX are unused (counter is not instantiated).
- When undefined: fixed data priority with the starvation counter, as above.

Decomposition:
- mycpu.vh gains:
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD constants.
  - ARB_SEL_INST=0 / ARB_SEL_DATA=1.
  - A default for STARVE_MAX.
- One sub-module, sram_wstrb_gen: combinational size + addr[1:0] + wr -> 4-bit write enable. It is reusable by exe_stage.
- Arbitration, counter and tag stay in sram_arbiter.

Test Plan:
1. Reset: hold resetn=0 with both req=1 -> all outputs 0. Release -> first grant in the 2nd cycle after release.
2. Inst only: inst_req=1 at addr 0x1c000000 for 3 cycles, with ram_rdata returning 0x11,0x22,0x33 -> inst_addr_ok=1 for 3 cycles, inst_data_ok 1 cycle later each, inst_rdata 0x11,0x22,0x33, data_data_ok=0 throughout.
3. Store byte: data_req=1, wr=1, size=0, addr=0x1002, wdata=0xAAAAAAAA -> ram_we=4'b0100, ram_addr=0x1000, data_data_ok=1 next cycle. Half at addr 0x1002 -> ram_we=4'b1100.
4. Starvation (STARVE_MAX=4, macro off): both req=1 continuously -> grant pattern D,D,D,D,I,D,D,D,D,I.
5. Round robin (SRAM_ARB_RR_EN defined): both req=1 continuously -> grants alternate I,D,I,D starting with I. Responses are tagged correctly every cycle.
6. Mid-op reset: grant a load at cycle N, drop resetn at cycle N+0.5 -> data_data_ok stays 0. After release, resp_vld=0 and starve_cnt=0.
